weight_fetch_ctrl: RTL

// Sequences one neuron's weight memory in lockstep with its incoming activation stream.

---
 rtl/weight_fetch_ctrl.sv | 74 +++++++
 1 files changed

// File: rtl/weight_fetch_ctrl.sv
// weight_fetch_ctrl: paces one neuron's weight reads to its activation stream and emits aligned MAC pairs
module weight_fetch_ctrl #(
    parameter int numWeight    = 3,
    parameter int addressWidth = 10,
    parameter int dataWidth    = 16
) (
    input  logic                    clk,
    input  logic                    rstn,
    input  logic                    clear,
    input  logic [dataWidth-1:0]    in_data,
    input  logic                    in_valid,
    output logic                    in_ready,
    output logic                    mem_ren,
    output logic [addressWidth-1:0] mem_radd,
    input  logic [dataWidth-1:0]    mem_rdata,
    output logic [dataWidth-1:0]    mac_act,
    output logic [dataWidth-1:0]    mac_wgt,
    output logic                    mac_valid,
    output logic                    mac_last,
    output logic                    done,
    output logic                    busy
);
    typedef enum logic [1:0] {IDLE, RUN, FLUSH} state_t;
    localparam logic [addressWidth-1:0] LAST = addressWidth'(numWeight - 1);
    state_t                  state_q, state_d;
    logic [addressWidth-1:0] addr_q, addr_d;
    logic [dataWidth-1:0]    act_q, act_d;
    logic                    v_q, v_d, last_q, last_d;
    logic                    accept, at_end;
    // Handshake, address sequencing and the one-cycle pair delay that matches read latency
    always_comb begin
        in_ready = rstn && !clear && state_q != FLUSH;
        accept   = in_valid && in_ready;
        at_end   = addr_q == LAST;
        state_d  = state_q;
        addr_d   = addr_q;
        if (clear) begin
            state_d = IDLE;
            addr_d  = '0;
        end else if (state_q == FLUSH) begin
            state_d = IDLE;
        end else if (accept) begin
            state_d = at_end ? FLUSH : RUN;
            addr_d  = at_end ? '0 : addr_q + 1'b1;
        end
        v_d    = accept;
        last_d = accept && at_end;
        act_d  = accept ? in_data : act_q;
    end
    // State and pair registers; reset also clears the held activation
    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q <= IDLE;
            addr_q  <= '0;
            act_q   <= '0;
            v_q     <= 1'b0;
            last_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            act_q   <= act_d;
            v_q     <= v_d;
            last_q  <= last_d;
        end
    end
    assign mem_ren   = accept;
    assign mem_radd  = addr_q;
    assign mac_act   = act_q;
    assign mac_wgt   = mem_rdata;
    assign mac_valid = v_q;
    assign mac_last  = v_q && last_q;
    assign done      = state_q == FLUSH && !clear;
    assign busy      = state_q != IDLE;
endmodule
